// File: rtl/rn_rename_alloc_pkg.sv
// Shared rename-stage types and sizing: ROB tag width, architectural register count, RAT entry layout.
// ROB_ENTRY_WIDTH may be overridden on the command line; it defaults to an 8-entry ROB.
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 3
`endif

package rn_rename_alloc_pkg;

    localparam int ROB_W     = `ROB_ENTRY_WIDTH;
    localparam int ROB_DEPTH = 2 ** ROB_W;
    localparam int NUM_AREGS = 32;

    typedef struct packed {
        logic             busy;
        logic [ROB_W-1:0] tag;
    } rat_entry_t;

endpackage

// File: rtl/rn_rat.sv
// Register alias table: two combinational read ports, one alloc write, one tag-matched
// commit clear and a bulk flush clear. Alloc wins over a commit clear to the same register.
module rn_rat
    import rn_rename_alloc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [4:0]       rd_addr1,
    input  logic [4:0]       rd_addr2,
    output rat_entry_t       rd_data1,
    output rat_entry_t       rd_data2,
    input  logic             alloc_we,
    input  logic [4:0]       alloc_rd,
    input  logic [ROB_W-1:0] alloc_tag,
    input  logic             clr_we,
    input  logic [4:0]       clr_rd,
    input  logic [ROB_W-1:0] clr_tag
);

    rat_entry_t rat [NUM_AREGS];

    // x0 is hardwired zero, so its lookup never reflects storage.
    assign rd_data1 = (rd_addr1 == '0) ? '0 : rat[rd_addr1];
    assign rd_data2 = (rd_addr2 == '0) ? '0 : rat[rd_addr2];

    // NOTE: the whole table is reset (not just busy) so tags read as 0 after reset;
    // a flush only drops busy bits, leaving stale tags that nothing consumes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_AREGS; i++) rat[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < NUM_AREGS; i++) rat[i].busy <= 1'b0;
        end else begin
            // Clear only if the retiring instruction is still the latest producer.
            if (clr_we && clr_rd != '0 && rat[clr_rd].busy && rat[clr_rd].tag == clr_tag)
                rat[clr_rd].busy <= 1'b0;
            // NOTE: non-blocking updates let the later alloc write override the clear above
            // when both hit the same register, which gives alloc-over-clear priority.
            if (alloc_we && alloc_rd != '0)
                rat[alloc_rd] <= '{busy: 1'b1, tag: alloc_tag};
        end
    end

endmodule

// File: rtl/rn_rename_alloc.sv
// Rename stage: allocates ROB tags from an in-order ring, renames rs1/rs2 through the RAT.
// Optional macro RN_COMMIT_BYPASS_EN: a source produced by the retiring tag reports not-busy.
module rn_rename_alloc
    import rn_rename_alloc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             EN,
    input  logic             flush,
    input  logic             stall,
    input  logic             valid_ID,
    input  logic             RegWrite_ID,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic [4:0]       rd_ID,
    input  logic             commit_valid,
    input  logic [4:0]       commit_rd,
    input  logic [ROB_W-1:0] commit_tag,
    output logic [ROB_W-1:0] ROB_dest_RN,
    output logic [ROB_W-1:0] rs1_tag_RN,
    output logic             rs1_busy_RN,
    output logic [ROB_W-1:0] rs2_tag_RN,
    output logic             rs2_busy_RN,
    output logic             alloc_RN,
    output logic             stall_RN
);

    logic [ROB_W-1:0] head, tail;
    logic [ROB_W:0]   count;
    logic             full, alloc_fire, commit_fire, flush_fire;
    rat_entry_t       src1, src2;

    assign full        = (count == (ROB_W+1)'(ROB_DEPTH));
    assign alloc_fire  = EN & valid_ID & ~stall & ~full & ~flush;
    // A commit against an empty ROB is illegal and is dropped here rather than underflowing.
    assign commit_fire = EN & commit_valid & ~flush & (count != '0);
    assign flush_fire  = EN & flush;

    assign ROB_dest_RN = tail;
    assign alloc_RN    = alloc_fire;
    assign stall_RN    = full;

    rn_rat u_rat (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush_fire),
        .rd_addr1  (rs1_ID),
        .rd_addr2  (rs2_ID),
        .rd_data1  (src1),
        .rd_data2  (src2),
        .alloc_we  (alloc_fire & RegWrite_ID),
        .alloc_rd  (rd_ID),
        .alloc_tag (tail),
        .clr_we    (commit_fire),
        .clr_rd    (commit_rd),
        .clr_tag   (commit_tag)
    );

    // NOTE: every output is assigned a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rs1_tag_RN  = src1.tag;
        rs2_tag_RN  = src2.tag;
        rs1_busy_RN = src1.busy;
        rs2_busy_RN = src2.busy;
`ifdef RN_COMMIT_BYPASS_EN
        if (commit_valid && src1.tag == commit_tag) rs1_busy_RN = 1'b0;
        if (commit_valid && src2.tag == commit_tag) rs2_busy_RN = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_fire) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (alloc_fire)  tail <= tail + 1'b1;
            if (commit_fire) head <= head + 1'b1;
            case ({alloc_fire, commit_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    a_commit_not_empty: assert property (@(posedge clk) disable iff (rst)
        (EN && commit_valid && !flush) |-> (count != '0));

    a_commit_is_head: assert property (@(posedge clk) disable iff (rst)
        (EN && commit_valid && !flush) |-> (commit_tag == head));

endmodule

// File: tb/tb_rn_rename_alloc.sv
// Directed bench for rn_rename_alloc; expectations are hand-derived from the ring/RAT behaviour.
module tb_rn_rename_alloc;
    import rn_rename_alloc_pkg::*;

    logic             clk = 1'b0;
    logic             rst, EN, flush, stall, valid_ID, RegWrite_ID, commit_valid;
    logic [4:0]       rs1_ID, rs2_ID, rd_ID, commit_rd;
    logic [ROB_W-1:0] commit_tag, ROB_dest_RN, rs1_tag_RN, rs2_tag_RN;
    logic             rs1_busy_RN, rs2_busy_RN, alloc_RN, stall_RN;

    int errors = 0;
    int checks = 0;

`ifdef RN_COMMIT_BYPASS_EN
    localparam int BYP_BUSY = 0;
`else
    localparam int BYP_BUSY = 1;
`endif

    rn_rename_alloc dut (
        .clk(clk), .rst(rst), .EN(EN), .flush(flush), .stall(stall),
        .valid_ID(valid_ID), .RegWrite_ID(RegWrite_ID),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag),
        .ROB_dest_RN(ROB_dest_RN), .rs1_tag_RN(rs1_tag_RN), .rs1_busy_RN(rs1_busy_RN),
        .rs2_tag_RN(rs2_tag_RN), .rs2_busy_RN(rs2_busy_RN),
        .alloc_RN(alloc_RN), .stall_RN(stall_RN)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look1(input string tag, input logic [4:0] r, input int busy, input int t);
        rs1_ID = r;
        #1;
        check({tag, "_busy"}, 32'(rs1_busy_RN), busy);
        check({tag, "_tag"},  32'(rs1_tag_RN),  t);
    endtask

    task automatic alloc(input logic [4:0] rd, input logic rw);
        valid_ID = 1'b1; RegWrite_ID = rw; rd_ID = rd;
        tick();
        valid_ID = 1'b0; RegWrite_ID = 1'b0;
    endtask

    task automatic commit(input logic [4:0] rd, input int t);
        commit_valid = 1'b1; commit_rd = rd; commit_tag = ROB_W'(t);
        tick();
        commit_valid = 1'b0; commit_rd = '0; commit_tag = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; EN = 1'b1; flush = 1'b0; stall = 1'b0;
        valid_ID = 1'b0; RegWrite_ID = 1'b0;
        rs1_ID = '0; rs2_ID = '0; rd_ID = '0;
        commit_valid = 1'b0; commit_rd = '0; commit_tag = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        rs1_ID = 5'd5; rs2_ID = 5'd6;
        #1;
        check("rst_dest",  32'(ROB_dest_RN), 0);
        check("rst_stall", 32'(stall_RN), 0);
        check("rst_alloc", 32'(alloc_RN), 0);
        check("rst_busy1", 32'(rs1_busy_RN), 0);
        check("rst_tag2",  32'(rs2_tag_RN), 0);

        // add x3,x1,x2
        valid_ID = 1'b1; RegWrite_ID = 1'b1; rd_ID = 5'd3; rs1_ID = 5'd1; rs2_ID = 5'd2;
        #1;
        check("t1_alloc", 32'(alloc_RN), 1);
        check("t1_dest",  32'(ROB_dest_RN), 0);
        check("t1_busy1", 32'(rs1_busy_RN), 0);
        check("t1_busy2", 32'(rs2_busy_RN), 0);
        tick();
        valid_ID = 1'b0;
        look1("t1_x3", 5'd3, 1, 0);
        check("t1_dest_next", 32'(ROB_dest_RN), 1);

        // add x3,x3,x3 reads the old x3 mapping, then remaps x3 to tag 1
        valid_ID = 1'b1; rs2_ID = 5'd3;
        look1("t1_old_x3", 5'd3, 1, 0);
        tick();
        valid_ID = 1'b0; RegWrite_ID = 1'b0;
        look1("t1_new_x3", 5'd3, 1, 1);

        // Reset mid-operation, with an instruction present
        valid_ID = 1'b1;
        do_reset();
        valid_ID = 1'b0;
        #1;
        check("rst2_dest", 32'(ROB_dest_RN), 0);
        look1("rst2_x3", 5'd3, 0, 0);

        // Fill the 8-entry ROB
        valid_ID = 1'b1;
        for (int i = 0; i < ROB_DEPTH; i++) begin
            #1;
            check("fill_dest", 32'(ROB_dest_RN), 32'(i));
            tick();
        end
        check("full_stall", 32'(stall_RN), 1);
        check("full_alloc", 32'(alloc_RN), 0);
        check("full_dest",  32'(ROB_dest_RN), 0);
        tick();
        check("full_hold_dest", 32'(ROB_dest_RN), 0);
        // Commit while full: alloc still blocked this cycle, one slot frees after the edge
        commit_valid = 1'b1; commit_tag = 3'(0);
        #1;
        check("full_cm_alloc", 32'(alloc_RN), 0);
        check("full_cm_stall", 32'(stall_RN), 1);
        tick();
        check("after_cm_stall", 32'(stall_RN), 0);
        check("after_cm_dest",  32'(ROB_dest_RN), 0);
        // Alloc + commit together: count stays at 7
        commit_tag = 3'(1);
        #1;
        check("ac_alloc", 32'(alloc_RN), 1);
        tick();
        commit_valid = 1'b0; commit_tag = '0;
        check("ac_stall", 32'(stall_RN), 0);
        check("ac_dest",  32'(ROB_dest_RN), 1);
        tick();
        valid_ID = 1'b0;
        check("refill_stall", 32'(stall_RN), 1);
        check("refill_dest",  32'(ROB_dest_RN), 2);

        // Stale commit must not clear a newer mapping
        do_reset();
        alloc(5'd1, 1'b1);   // tag 0
        alloc(5'd1, 1'b1);   // tag 1
        alloc(5'd5, 1'b1);   // tag 2
        alloc(5'd9, 1'b1);   // tag 3
        alloc(5'd5, 1'b1);   // tag 4
        look1("t3_x5", 5'd5, 1, 4);
        commit(5'd1, 0);
        look1("t3_x1_stale", 5'd1, 1, 1);
        commit(5'd1, 1);
        look1("t3_x1_clear", 5'd1, 0, 1);
        commit(5'd5, 2);
        look1("t3_x5_keep", 5'd5, 1, 4);

        // Source produced by the retiring tag
        commit_valid = 1'b1; commit_rd = 5'd9; commit_tag = 3'(3); rs2_ID = 5'd0;
        look1("t6_x9", 5'd9, BYP_BUSY, 3);
        check("t6_x0_busy", 32'(rs2_busy_RN), 0);
        check("t6_x0_tag",  32'(rs2_tag_RN), 0);
        tick();
        commit_valid = 1'b0; commit_rd = '0; commit_tag = '0;
        look1("t6_x9_after", 5'd9, 0, 3);
        commit(5'd5, 4);
        look1("t3_x5_clear", 5'd5, 0, 4);

        // Alloc rd=7 while committing its previous producer
        alloc(5'd7, 1'b1);   // tag 5
        look1("t4_x7_old", 5'd7, 1, 5);
        commit_valid = 1'b1; commit_rd = 5'd7; commit_tag = 3'(5);
        alloc(5'd7, 1'b1);   // tag 6
        commit_valid = 1'b0; commit_rd = '0; commit_tag = '0;
        look1("t4_x7_new", 5'd7, 1, 6);

        // Build count=5 (tags 6..2 live), then flush
        for (int i = 0; i < 4; i++) alloc(5'd10, 1'b1);
        #1;
        check("t5_dest_pre", 32'(ROB_dest_RN), 3);
        // Flush with EN low is ignored
        EN = 1'b0; flush = 1'b1; valid_ID = 1'b1;
        #1;
        check("en0_alloc", 32'(alloc_RN), 0);
        tick();
        check("en0_dest", 32'(ROB_dest_RN), 3);
        look1("en0_x10", 5'd10, 1, 2);
        EN = 1'b1;
        #1;
        check("fl_alloc", 32'(alloc_RN), 0);
        tick();
        flush = 1'b0; valid_ID = 1'b0;
        check("fl_dest",  32'(ROB_dest_RN), 0);
        check("fl_stall", 32'(stall_RN), 0);
        look1("fl_x7",  5'd7, 0, 6);
        look1("fl_x10", 5'd10, 0, 2);
        // count restarted at 0: exactly 8 allocs reach full
        valid_ID = 1'b1;
        for (int i = 0; i < ROB_DEPTH - 1; i++) tick();
        check("fl_not_full", 32'(stall_RN), 0);
        check("fl_dest7",    32'(ROB_dest_RN), 7);
        tick();
        valid_ID = 1'b0;
        check("fl_full", 32'(stall_RN), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
